tick_scheduler: RTL and testbench
=================================

Name: tick_scheduler

Overview:
- Central clock-enable scheduler for the VGA snake design.
- Takes the 100 MHz system clock and produces three single-cycle enable strobes:
  - pixel enable for the VGA timing chain (25 MHz equivalent);
  - game-step tick whose rate follows a selectable speed level;
  - input-sample tick for button debouncing.
- A small run/pause/idle FSM gates the game-step tick. Speed changes apply only at step boundaries so snake motion never jitters.

Parameters:
- PIX_DIV, 4, system cycles per pix_en pulse (must be >= 2).
- STEP_DIV_BASE, 25000000, cycles per step_tick at speed level 0; must be >= 16 so level 3 has a period of at least 2.
- SAMPLE_DIV, 1000000, cycles per sample_tick (must be >= 2).
- CNT_W, 32, width of all internal counters (must hold the largest DIV value).

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-low reset.
- run_req  input  1  single-cycle request to start or resume stepping.
- pause_req  input  1  single-cycle request to freeze stepping.
- stop_req  input  1  single-cycle request to return to idle and clear the step phase.
- speed_in  input  2  requested speed level (0 slowest, 3 fastest).
- speed_load  input  1  capture speed_in into the pending register.
- pix_en  output  1  one-cycle strobe every PIX_DIV cycles.
- step_tick  output  1  one-cycle strobe per game step, RUN state only.
- sample_tick  output  1  one-cycle strobe every SAMPLE_DIV cycles.
- state  output  2  current FSM state: 00 IDLE, 01 RUN, 10 PAUSED.
- speed_cur  output  2  speed level currently in effect.

Behaviour:
- Reset (reset=0, asynchronous): all counters 0, pix_en=0, step_tick=0, sample_tick=0, state=IDLE, speed_cur=0, pending speed=0, pending-valid=0.
- All outputs are registered.
- pix_en:
  - Free-running counter 0..PIX_DIV-1, independent of the FSM.
  - pix_en=1 for exactly one cycle when the counter wraps.
  - First pulse occurs in the cycle after the PIX_DIV-th rising edge following reset release; period is exactly PIX_DIV.
- sample_tick: same scheme with SAMPLE_DIV, also FSM-independent.
- Step period P = STEP_DIV_BASE >> speed_cur (integer shift, truncating).
- FSM transitions, evaluated each cycle with priority stop_req > pause_req > run_req:
  - IDLE: run_req -> RUN, step counter cleared to 0. pause_req ignored.
  - RUN: step counter increments. When it reaches P-1, the counter returns to 0 and step_tick pulses next cycle. pause_req -> PAUSED; stop_req -> IDLE.
  - PAUSED: step counter holds its value and no step_tick is issued. run_req -> RUN, resuming from the held count with no phase loss. stop_req -> IDLE.
  - stop_req from any state -> IDLE, step counter cleared to 0, and any step_tick that would fire that cycle is suppressed.
- Speed loading:
  - speed_load=1 latches speed_in into pending and sets pending-valid.
  - In IDLE or PAUSED, pending applies on the next cycle: speed_cur updates and pending-valid clears.
  - In RUN, pending applies only on the cycle the step counter wraps, so the new period starts with the next step.
  - A later speed_load before application overwrites pending (last write wins).
  - speed_load in the same cycle as a wrap is not applied at that wrap; it is held until the next boundary.
- PAUSED -> RUN with a held count >= the new, smaller P: on the next RUN cycle the counter wraps immediately and step_tick fires. No counter overflow or wrap-around past P.
- Reset asserted mid-operation forces the reset values immediately, without waiting for a clock edge.
- Requests arriving while reset is asserted are ignored.

Test Plan (PIX_DIV=4, STEP_DIV_BASE=16, SAMPLE_DIV=8):
- Release reset, idle 40 cycles -> pix_en pulses every 4 cycles, first at cycle 4; sample_tick every 8 cycles, first at cycle 8; step_tick never asserts; state=00.
- run_req at cycle 10, speed 0 -> state=01; step_tick every 16 cycles, first 16 cycles after entry.
- In RUN at level 0, speed_load with speed_in=2 mid-period -> current period finishes at 16; subsequent periods are 4; speed_cur changes at that wrap.
- RUN, pause_req after 10 counts, hold 20 cycles, run_req -> no step_tick while paused; next step_tick 6 cycles after resume.
- pause_req and stop_req in the same cycle while in RUN -> state=00 and the counter clears; a later run_req gives its first step_tick after a full 16 cycles.
- Assert reset for 1 cycle mid-RUN -> outputs return immediately to reset values; state=00, speed_cur=0; pix_en phase restarts.

Source files
------------

// File: rtl/tick_scheduler.sv
// Clock-enable scheduler: free-running pixel and input-sample strobes plus a
// run/pause/idle gated game-step tick whose period follows a speed level.
module tick_scheduler #(
    parameter int unsigned PIX_DIV       = 4,
    parameter int unsigned STEP_DIV_BASE = 25000000,
    parameter int unsigned SAMPLE_DIV    = 1000000,
    parameter int unsigned CNT_W         = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run_req,
    input  logic       pause_req,
    input  logic       stop_req,
    input  logic [1:0] speed_in,
    input  logic       speed_load,
    output logic       pix_en,
    output logic       step_tick,
    output logic       sample_tick,
    output logic [1:0] state,
    output logic [1:0] speed_cur
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10
    } state_t;

    logic [CNT_W-1:0] r_pix_cnt;
    logic             r_pix_en;
    logic [CNT_W-1:0] r_smp_cnt;
    logic             r_smp_en;

    state_t           r_state;
    logic [CNT_W-1:0] r_step_cnt;
    logic             r_step_tick;
    logic [1:0]       r_speed_cur;
    logic [1:0]       r_pend;
    logic             r_pend_vld;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_step_cnt_nxt;
    logic             w_step_tick_nxt;
    logic [1:0]       w_speed_nxt;
    logic [1:0]       w_pend_nxt;
    logic             w_pend_vld_nxt;
    logic             w_step_wrap;
    logic [CNT_W-1:0] w_period;
    logic [CNT_W-1:0] w_last;

    // Pixel-enable divider, independent of the FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pix_cnt <= '0;
            r_pix_en  <= 1'b0;
        end else if (r_pix_cnt == CNT_W'(PIX_DIV - 1)) begin
            r_pix_cnt <= '0;
            r_pix_en  <= 1'b1;
        end else begin
            r_pix_cnt <= r_pix_cnt + CNT_W'(1);
            r_pix_en  <= 1'b0;
        end
    end

    // Input-sample divider, independent of the FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_smp_cnt <= '0;
            r_smp_en  <= 1'b0;
        end else if (r_smp_cnt == CNT_W'(SAMPLE_DIV - 1)) begin
            r_smp_cnt <= '0;
            r_smp_en  <= 1'b1;
        end else begin
            r_smp_cnt <= r_smp_cnt + CNT_W'(1);
            r_smp_en  <= 1'b0;
        end
    end

    assign w_period = CNT_W'(STEP_DIV_BASE) >> r_speed_cur;
    assign w_last   = w_period - CNT_W'(1);

    // Step FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_step_cnt  <= '0;
            r_step_tick <= 1'b0;
            r_speed_cur <= 2'd0;
            r_pend      <= 2'd0;
            r_pend_vld  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_step_cnt  <= w_step_cnt_nxt;
            r_step_tick <= w_step_tick_nxt;
            r_speed_cur <= w_speed_nxt;
            r_pend      <= w_pend_nxt;
            r_pend_vld  <= w_pend_vld_nxt;
        end
    end

    // Next-state, step counter and speed application
    always_comb begin
        w_state_nxt     = r_state;
        w_step_cnt_nxt  = r_step_cnt;
        w_step_tick_nxt = 1'b0;
        w_step_wrap     = 1'b0;
        w_speed_nxt     = r_speed_cur;
        w_pend_nxt      = speed_load ? speed_in : r_pend;
        w_pend_vld_nxt  = r_pend_vld | speed_load;

        if (stop_req) begin
            w_state_nxt    = ST_IDLE;
            w_step_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (run_req) begin
                        w_state_nxt    = ST_RUN;
                        w_step_cnt_nxt = '0;
                    end
                end
                ST_RUN: begin
                    if (pause_req) begin
                        w_state_nxt = ST_PAUSED;
                    end else if (r_step_cnt >= w_last) begin
                        // >= covers a held count left over from a slower speed
                        w_step_cnt_nxt  = '0;
                        w_step_tick_nxt = 1'b1;
                        w_step_wrap     = 1'b1;
                    end else begin
                        w_step_cnt_nxt = r_step_cnt + CNT_W'(1);
                    end
                end
                ST_PAUSED: begin
                    if (run_req) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt    = ST_IDLE;
                    w_step_cnt_nxt = '0;
                end
            endcase
        end

        // A load arriving this cycle stays pending for the next boundary
        if (r_pend_vld && ((r_state != ST_RUN) || w_step_wrap)) begin
            w_speed_nxt    = r_pend;
            w_pend_vld_nxt = speed_load;
        end
    end

    assign pix_en      = r_pix_en;
    assign sample_tick = r_smp_en;
    assign step_tick   = r_step_tick;
    assign state       = r_state;
    assign speed_cur   = r_speed_cur;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with small dividers (4 / 16 / 8).
module tb_tick_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       run_req;
    logic       pause_req;
    logic       stop_req;
    logic [1:0] speed_in;
    logic       speed_load;
    logic       pix_en;
    logic       step_tick;
    logic       sample_tick;
    logic [1:0] state;
    logic [1:0] speed_cur;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tick_scheduler #(
        .PIX_DIV      (4),
        .STEP_DIV_BASE(16),
        .SAMPLE_DIV   (8),
        .CNT_W        (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run_req    (run_req),
        .pause_req  (pause_req),
        .stop_req   (stop_req),
        .speed_in   (speed_in),
        .speed_load (speed_load),
        .pix_en     (pix_en),
        .step_tick  (step_tick),
        .sample_tick(sample_tick),
        .state      (state),
        .speed_cur  (speed_cur)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; run_req = 1'b0; pause_req = 1'b0; stop_req = 1'b0;
        speed_in = 2'd0; speed_load = 1'b0;
        tick; tick;
        checks++; if (pix_en !== 1'b0) begin errors++; $display("FAIL reset_pix got %0d exp 0", pix_en); end
        checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL reset_step got %0d exp 0", step_tick); end
        checks++; if (sample_tick !== 1'b0) begin errors++; $display("FAIL reset_sample got %0d exp 0", sample_tick); end
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if (speed_cur !== 2'd0) begin errors++; $display("FAIL reset_speed got %0d exp 0", speed_cur); end
        run_req = 1'b1;
        tick;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_run_ignored got %0d exp 0", state); end
        run_req = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_idle_dividers;
        for (int k = 1; k <= 40; k++) begin
            tick;
            checks++; if (pix_en !== (k % 4 == 0)) begin errors++; $display("FAIL idle_pix cyc %0d got %0d exp %0d", k, pix_en, (k % 4 == 0)); end
            checks++; if (sample_tick !== (k % 8 == 0)) begin errors++; $display("FAIL idle_sample cyc %0d got %0d exp %0d", k, sample_tick, (k % 8 == 0)); end
            checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL idle_step cyc %0d got %0d exp 0", k, step_tick); end
            checks++; if (state !== 2'b00) begin errors++; $display("FAIL idle_state cyc %0d got %0d exp 0", k, state); end
        end
    endtask

    task automatic test_run;
        run_req = 1'b1;
        tick;
        run_req = 1'b0;
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL run_enter got %0d exp 1", state); end
        for (int k = 1; k <= 32; k++) begin
            tick;
            checks++; if (step_tick !== (k % 16 == 0)) begin errors++; $display("FAIL run_step cyc %0d got %0d exp %0d", k, step_tick, (k % 16 == 0)); end
            checks++; if (state !== 2'b01) begin errors++; $display("FAIL run_state cyc %0d got %0d exp 1", k, state); end
        end
    endtask

    task automatic test_speed_change;
        logic exp_tick;
        logic [1:0] exp_spd;
        for (int j = 1; j <= 32; j++) begin
            tick;
            exp_tick = (j == 16) || (j > 16 && ((j - 16) % 4 == 0));
            exp_spd  = (j >= 16) ? 2'd2 : 2'd0;
            checks++; if (step_tick !== exp_tick) begin errors++; $display("FAIL speed_step cyc %0d got %0d exp %0d", j, step_tick, exp_tick); end
            checks++; if (speed_cur !== exp_spd) begin errors++; $display("FAIL speed_cur cyc %0d got %0d exp %0d", j, speed_cur, exp_spd); end
            if (j == 5) begin
                speed_in = 2'd2; speed_load = 1'b1;
            end else begin
                speed_load = 1'b0;
            end
        end
    endtask

    task automatic test_idle_speed;
        stop_req = 1'b1;
        tick;
        stop_req = 1'b0;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL stop_state got %0d exp 0", state); end
        speed_in = 2'd0; speed_load = 1'b1;
        tick;
        speed_load = 1'b0;
        checks++; if (speed_cur !== 2'd2) begin errors++; $display("FAIL idle_speed_latch got %0d exp 2", speed_cur); end
        tick;
        checks++; if (speed_cur !== 2'd0) begin errors++; $display("FAIL idle_speed_apply got %0d exp 0", speed_cur); end
    endtask

    task automatic test_pause_resume;
        run_req = 1'b1;
        tick;
        run_req = 1'b0;
        for (int k = 1; k <= 10; k++) tick;
        pause_req = 1'b1;
        tick;
        pause_req = 1'b0;
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL pause_state got %0d exp 2", state); end
        for (int k = 1; k <= 20; k++) begin
            tick;
            checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL paused_step cyc %0d got %0d exp 0", k, step_tick); end
        end
        run_req = 1'b1;
        tick;
        run_req = 1'b0;
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL resume_state got %0d exp 1", state); end
        for (int k = 1; k <= 6; k++) begin
            tick;
            checks++; if (step_tick !== (k == 6)) begin errors++; $display("FAIL resume_step cyc %0d got %0d exp %0d", k, step_tick, (k == 6)); end
        end
    endtask

    task automatic test_stop_priority;
        for (int k = 1; k <= 15; k++) tick;
        pause_req = 1'b1; stop_req = 1'b1;
        tick;
        pause_req = 1'b0; stop_req = 1'b0;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL stop_pause_state got %0d exp 0", state); end
        checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL stop_suppress got %0d exp 0", step_tick); end
        run_req = 1'b1;
        tick;
        run_req = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick;
            checks++; if (step_tick !== (k == 16)) begin errors++; $display("FAIL restart_step cyc %0d got %0d exp %0d", k, step_tick, (k == 16)); end
        end
    endtask

    task automatic test_paused_speed_up;
        stop_req = 1'b1;
        tick;
        stop_req = 1'b0;
        run_req = 1'b1;
        tick;
        run_req = 1'b0;
        for (int k = 1; k <= 10; k++) tick;
        pause_req = 1'b1;
        tick;
        pause_req = 1'b0;
        speed_in = 2'd3; speed_load = 1'b1;
        tick;
        speed_load = 1'b0;
        tick;
        checks++; if (speed_cur !== 2'd3) begin errors++; $display("FAIL paused_speed got %0d exp 3", speed_cur); end
        run_req = 1'b1;
        tick;
        run_req = 1'b0;
        checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL fast_resume_r0 got %0d exp 0", step_tick); end
        tick;
        checks++; if (step_tick !== 1'b1) begin errors++; $display("FAIL fast_resume_wrap got %0d exp 1", step_tick); end
        for (int k = 1; k <= 4; k++) begin
            tick;
            checks++; if (step_tick !== (k % 2 == 0)) begin errors++; $display("FAIL fast_period cyc %0d got %0d exp %0d", k, step_tick, (k % 2 == 0)); end
        end
    endtask

    task automatic test_async_reset;
        reset = 1'b0;
        #1;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL async_state got %0d exp 0", state); end
        checks++; if (speed_cur !== 2'd0) begin errors++; $display("FAIL async_speed got %0d exp 0", speed_cur); end
        checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL async_step got %0d exp 0", step_tick); end
        run_req = 1'b1;
        tick; tick;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL async_run_ignored got %0d exp 0", state); end
        run_req = 1'b0;
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick;
            checks++; if (pix_en !== (k % 4 == 0)) begin errors++; $display("FAIL rst_pix cyc %0d got %0d exp %0d", k, pix_en, (k % 4 == 0)); end
            checks++; if (sample_tick !== (k % 8 == 0)) begin errors++; $display("FAIL rst_sample cyc %0d got %0d exp %0d", k, sample_tick, (k % 8 == 0)); end
        end
    endtask

    initial begin
        test_reset;
        test_idle_dividers;
        test_run;
        test_speed_change;
        test_idle_speed;
        test_pause_resume;
        test_stop_priority;
        test_paused_speed_up;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
